// File: rtl/gemm_c_writeback.sv
// gemm_c_writeback
// Output writeback stage behind the GeMM accelerator. Each wide tile write
// (M*N elements of OutDataWidth bits) is captured into a small circular
// buffer of Depth tiles. Tiles are then drained one element per beat to a
// narrow, element-addressed C memory port with a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   tile_we_i       tile write strobe from the accelerator
//   tile_addr_i     tile index for the strobed tile
//   tile_wdata_i    full tile; element e = m*N+n at [e*OutDataWidth +: OutDataWidth]
//   out_valid_o     element beat valid
//   out_ready_i     downstream accepts the current beat
//   out_addr_o      element address = tile_addr*M*N + e (mod 2^AddrWidth)
//   out_data_o      element data
//   occupancy_o     tiles held, including the one draining
//   overflow_o      sticky flag: a tile write was dropped because the buffer was full
//   idle_o          buffer empty, no beat pending
module gemm_c_writeback #(
  parameter int OutDataWidth = 32,
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int AddrWidth    = 16,
  parameter int Depth        = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         tile_we_i,
  input  logic [AddrWidth-1:0]         tile_addr_i,
  input  logic [OutDataWidth*M*N-1:0]  tile_wdata_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [AddrWidth-1:0]         out_addr_o,
  output logic [OutDataWidth-1:0]      out_data_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o,
  output logic                         overflow_o,
  output logic                         idle_o
);

  localparam int Elems = M * N;
  localparam int ElemW = (Elems > 1) ? $clog2(Elems) : 1;
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int OccW  = $clog2(Depth + 1);
  localparam int TileW = OutDataWidth * Elems;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]      occ_q, occ_d;
  logic [ElemW-1:0]     elem_q, elem_d;
  logic                 overflow_q, overflow_d;

  logic [AddrWidth-1:0] tile_addr_q [Depth];
  logic [TileW-1:0]     tile_data_q [Depth];

  logic                 draining;
  logic                 beat;
  logic                 last_beat;
  logic                 full;
  logic                 push;
  logic [TileW-1:0]     head_data;
  logic [OutDataWidth-1:0] head_elems [Elems];

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full buffer can still accept a tile on the cycle its head tile
  // finishes, since that slot frees up at the same edge.
  always_comb begin
    draining  = (state_q == DRAIN);
    beat      = draining && out_ready_i;
    last_beat = beat && (elem_q == ElemW'(Elems - 1));
    full      = (occ_q == OccW'(Depth));
    push      = tile_we_i && (!full || last_beat);
  end

  // Next-state logic for the FSM, pointers, element counter and flags.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    elem_d     = elem_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end else if (tile_we_i) begin
      overflow_d = 1'b1;
    end

    if (last_beat) begin
      elem_d   = '0;
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else if (beat) begin
      elem_d = elem_q + 1'b1;
    end

    case ({push, last_beat})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_beat && !push && (occ_q == OccW'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset throws away every buffered tile at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      elem_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      elem_q     <= elem_d;
      overflow_q <= overflow_d;
    end
  end

  // Tile storage needs no reset: it is only read while DRAIN says it is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tile_addr_q[wr_ptr_q] <= tile_addr_i;
      tile_data_q[wr_ptr_q] <= tile_wdata_i;
    end
  end

  // Beat outputs come straight from the head slot and counter, so they stay
  // put while the downstream stalls and are forced to zero when idle.
  always_comb begin
    head_data = tile_data_q[rd_ptr_q];
    for (int i = 0; i < Elems; i++) begin
      head_elems[i] = head_data[i*OutDataWidth +: OutDataWidth];
    end
    out_valid_o = draining;
    out_addr_o  = '0;
    out_data_o  = '0;
    if (draining) begin
      out_addr_o = tile_addr_q[rd_ptr_q] * AddrWidth'(Elems) + AddrWidth'(elem_q);
      out_data_o = head_elems[elem_q];
    end
    occupancy_o = occ_q;
    overflow_o  = overflow_q;
    idle_o      = (occ_q == '0);
  end

endmodule

// File: tb/tb_gemm_c_writeback.sv
// tb_gemm_c_writeback
// Self-checking bench for gemm_c_writeback. A queue-of-tiles model predicts
// every output on every cycle; directed scenarios add literal checks on the
// accepted beat stream, followed by a randomized push/backpressure phase.
module tb_gemm_c_writeback;

  localparam int W     = 32;
  localparam int M     = 4;
  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int DEPTH = 2;
  localparam int E     = M * N;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              tile_we_i = 1'b0;
  logic [AW-1:0]     tile_addr_i = '0;
  logic [W*E-1:0]    tile_wdata_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [AW-1:0]     out_addr_o;
  logic [W-1:0]      out_data_o;
  logic [$clog2(DEPTH+1)-1:0] occupancy_o;
  logic              overflow_o;
  logic              idle_o;

  gemm_c_writeback #(
    .OutDataWidth(W),
    .M(M),
    .N(N),
    .AddrWidth(AW),
    .Depth(DEPTH)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .tile_we_i(tile_we_i),
    .tile_addr_i(tile_addr_i),
    .tile_wdata_i(tile_wdata_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o),
    .out_data_o(out_data_o),
    .occupancy_o(occupancy_o),
    .overflow_o(overflow_o),
    .idle_o(idle_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int maxOcc = 0;
  logic [AW-1:0] logAddr[$];
  logic [W-1:0]  logData[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: a FIFO of whole tiles plus the index of the element
  // currently offered from the head tile.
  typedef struct {
    logic [AW-1:0]  addr;
    logic [W*E-1:0] data;
  } tile_t;

  tile_t mq[$];
  int    mHead = 0;
  bit    mOvf = 1'b0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      mHead = 0;
      mOvf = 1'b0;
    end else begin
      if (mq.size() > 0 && out_ready_i) begin
        if (mHead == E - 1) begin
          mHead = 0;
          void'(mq.pop_front());
        end else begin
          mHead++;
        end
      end
      if (tile_we_i) begin
        if (mq.size() < DEPTH) begin
          mq.push_back('{addr: tile_addr_i, data: tile_wdata_i});
        end else begin
          mOvf = 1'b1;
        end
      end
    end
  end

  function automatic logic [AW-1:0] expAddr();
    if (mq.size() == 0) return '0;
    return AW'(int'(mq[0].addr) * E + mHead);
  endfunction

  function automatic logic [W-1:0] expData();
    if (mq.size() == 0) return '0;
    return mq[0].data[mHead*W +: W];
  endfunction

  // Compare every output against the model on every falling edge and log
  // beats that will be accepted at the next rising edge.
  always @(negedge clk_i) begin
    checkOutput("out_valid", 64'(out_valid_o), 64'(mq.size() > 0));
    checkOutput("out_addr", 64'(out_addr_o), 64'(expAddr()));
    checkOutput("out_data", 64'(out_data_o), 64'(expData()));
    checkOutput("occupancy", 64'(occupancy_o), 64'(mq.size()));
    checkOutput("overflow", 64'(overflow_o), 64'(mOvf));
    checkOutput("idle", 64'(idle_o), 64'(mq.size() == 0));
    if (int'(occupancy_o) > maxOcc) maxOcc = int'(occupancy_o);
    if (rst_ni && out_valid_o && out_ready_i) begin
      logAddr.push_back(out_addr_o);
      logData.push_back(out_data_o);
    end
  end

  function automatic logic [W*E-1:0] makeTile(input int base);
    logic [W*E-1:0] t;
    for (int e = 0; e < E; e++) t[e*W +: W] = W'(base + e);
    return t;
  endfunction

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Present one tile write for exactly one rising edge.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [W*E-1:0] data);
    tile_we_i = 1'b1;
    tile_addr_i = addr;
    tile_wdata_i = data;
    cycle();
    tile_we_i = 1'b0;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    repeat (2) cycle();
    rst_ni = 1'b1;
    cycle();
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (!idle_o && n < maxCycles) begin
      cycle();
      n++;
    end
    checkOutput("drain_done", 64'(idle_o), 64'd1);
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
  endtask

  bit readyPat[3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    $display("[TB] starting");
    doReset();
    checkOutput("reset_valid", 64'(out_valid_o), 64'd0);
    checkOutput("reset_idle", 64'(idle_o), 64'd1);
    checkOutput("reset_occ", 64'(occupancy_o), 64'd0);
    checkOutput("reset_addr", 64'(out_addr_o), 64'd0);

    // Single tile at full rate.
    clearLog();
    out_ready_i = 1'b1;
    applyStimulus(16'd3, makeTile(32'h100));
    repeat (15) cycle();
    checkOutput("single_last_valid", 64'(out_valid_o), 64'd1);
    checkOutput("single_last_addr", 64'(out_addr_o), 64'd63);
    cycle();
    checkOutput("single_done_valid", 64'(out_valid_o), 64'd0);
    checkOutput("single_done_idle", 64'(idle_o), 64'd1);
    checkOutput("single_count", 64'(logAddr.size()), 64'd16);
    if (logAddr.size() == 16) begin
      checkOutput("single_first_addr", 64'(logAddr[0]), 64'd48);
      checkOutput("single_first_data", 64'(logData[0]), 64'h100);
      checkOutput("single_last_data", 64'(logData[15]), 64'h10F);
    end

    // Backpressure with a 1,0,0 ready pattern.
    clearLog();
    out_ready_i = 1'b0;
    applyStimulus(16'd3, makeTile(32'h100));
    for (int c = 0; c < 200 && logAddr.size() < 16; c++) begin
      out_ready_i = readyPat[c % 3];
      cycle();
    end
    out_ready_i = 1'b1;
    waitIdle(20);
    checkOutput("bp_count", 64'(logAddr.size()), 64'd16);
    for (int i = 0; i < 16 && i < logAddr.size(); i++) begin
      checkOutput("bp_addr", 64'(logAddr[i]), 64'(48 + i));
      checkOutput("bp_data", 64'(logData[i]), 64'(32'h100 + i));
    end

    // Back-to-back tiles 0 and 1.
    clearLog();
    maxOcc = 0;
    applyStimulus(16'd0, makeTile(32'h000));
    applyStimulus(16'd1, makeTile(32'h010));
    waitIdle(60);
    checkOutput("b2b_count", 64'(logAddr.size()), 64'd32);
    checkOutput("b2b_maxocc", 64'(maxOcc), 64'd2);
    for (int i = 0; i < 32 && i < logAddr.size(); i++) begin
      checkOutput("b2b_addr", 64'(logAddr[i]), 64'(i));
      checkOutput("b2b_data", 64'(logData[i]), 64'(i));
    end

    // Overflow: third tile dropped while stalled.
    clearLog();
    out_ready_i = 1'b0;
    applyStimulus(16'd5, makeTile(32'h500));
    applyStimulus(16'd6, makeTile(32'h600));
    applyStimulus(16'd7, makeTile(32'h700));
    checkOutput("ovf_flag", 64'(overflow_o), 64'd1);
    checkOutput("ovf_occ", 64'(occupancy_o), 64'd2);
    out_ready_i = 1'b1;
    waitIdle(60);
    checkOutput("ovf_sticky", 64'(overflow_o), 64'd1);
    checkOutput("ovf_count", 64'(logAddr.size()), 64'd32);
    for (int i = 0; i < 32 && i < logAddr.size(); i++) begin
      checkOutput("ovf_addr", 64'(logAddr[i]), 64'(80 + i));
    end

    // Push coinciding with the final pop of a full buffer.
    doReset();
    clearLog();
    out_ready_i = 1'b1;
    applyStimulus(16'd8, makeTile(32'h800));
    applyStimulus(16'd9, makeTile(32'h900));
    repeat (14) cycle();
    checkOutput("fp_occ_before", 64'(occupancy_o), 64'd2);
    checkOutput("fp_head_last", 64'(out_addr_o), 64'd143);
    applyStimulus(16'd10, makeTile(32'hA00));
    checkOutput("fp_overflow", 64'(overflow_o), 64'd0);
    checkOutput("fp_occ_after", 64'(occupancy_o), 64'd2);
    waitIdle(80);
    checkOutput("fp_count", 64'(logAddr.size()), 64'd48);
    for (int i = 0; i < 48 && i < logAddr.size(); i++) begin
      checkOutput("fp_addr", 64'(logAddr[i]), 64'(128 + i));
    end

    // Reset in the middle of a drain.
    clearLog();
    applyStimulus(16'd2, makeTile(32'h200));
    repeat (7) cycle();
    checkOutput("rst_pre_addr", 64'(out_addr_o), 64'd39);
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(out_valid_o), 64'd0);
    checkOutput("rst_addr", 64'(out_addr_o), 64'd0);
    checkOutput("rst_data", 64'(out_data_o), 64'd0);
    checkOutput("rst_occ", 64'(occupancy_o), 64'd0);
    checkOutput("rst_idle", 64'(idle_o), 64'd1);
    cycle();
    rst_ni = 1'b1;
    cycle();
    checkOutput("rst_after_idle", 64'(idle_o), 64'd1);
    clearLog();
    applyStimulus(16'd4, makeTile(32'h400));
    waitIdle(40);
    checkOutput("rst_next_count", 64'(logAddr.size()), 64'd16);
    if (logAddr.size() > 0) begin
      checkOutput("rst_next_addr", 64'(logAddr[0]), 64'd64);
      checkOutput("rst_next_data", 64'(logData[0]), 64'h400);
    end

    // Randomized pushes and backpressure against the model.
    for (int c = 0; c < 600; c++) begin
      tile_we_i = ($urandom_range(0, 7) == 0);
      tile_addr_i = AW'($urandom);
      for (int e = 0; e < E; e++) tile_wdata_i[e*W +: W] = $urandom;
      out_ready_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
    tile_we_i = 1'b0;
    out_ready_i = 1'b1;
    waitIdle(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
